muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for the RV32M ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).

---
 rtl/muldiv_seq_pkg.sv | 50 +++++
 rtl/muldiv_seq_step.sv | 50 +++++
 rtl/muldiv_seq.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: op codes,
// FSM state encoding, iteration modes and op-classification helpers.
package muldiv_seq_pkg;

    // Default operand/result width
    localparam int MXLEN = 32;

    // M-extension op codes as presented on req_op
    localparam logic [4:0] ALU_MUL    = 5'h10;
    localparam logic [4:0] ALU_MULH   = 5'h11;
    localparam logic [4:0] ALU_MULHSU = 5'h12;
    localparam logic [4:0] ALU_MULHU  = 5'h13;
    localparam logic [4:0] ALU_DIV    = 5'h14;
    localparam logic [4:0] ALU_DIVU   = 5'h15;
    localparam logic [4:0] ALU_REM    = 5'h16;
    localparam logic [4:0] ALU_REMU   = 5'h17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_t;

    typedef enum logic {
        STEP_MUL,
        STEP_DIV
    } step_mode_t;

    function automatic logic is_mul_op(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    // rs1 is treated as signed for MUL, MULH, MULHSU, DIV and REM
    function automatic logic a_is_signed(input logic [4:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) ||
               (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    // rs2 is treated as signed only for MULH, DIV and REM
    function automatic logic b_is_signed(input logic [4:0] op);
        return (op == ALU_MULH) || (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage

// File: rtl/muldiv_seq_step.sv
// One combinational iteration of the sequencer datapath.
//  Multiply: acc += opa when opb[0]; opa (multiplicand) shifts left,
//            opb (multiplier) shifts right.
//  Divide  : restoring step; acc holds the partial remainder, opa[XLEN-1:0]
//            the divisor, opb the dividend shifting out / quotient shifting in.
module muldiv_seq_step
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = MXLEN
) (
    input  logic                div_mode,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [2*XLEN-1:0]   opa,
    input  logic [XLEN-1:0]     opb,
    output logic [2*XLEN-1:0]   acc_next,
    output logic [2*XLEN-1:0]   opa_next,
    output logic [XLEN-1:0]     opb_next
);

    logic [XLEN:0]   shifted;
    logic [XLEN:0]   divisor;
    logic [XLEN-1:0] diff;

    // Single shift-add or restoring-subtract iteration
    always_comb begin
        acc_next = acc;
        opa_next = opa;
        opb_next = opb;
        shifted  = {acc[XLEN-1:0], opb[XLEN-1]};
        divisor  = {1'b0, opa[XLEN-1:0]};
        // The true difference is below the divisor, so XLEN bits hold it exactly
        diff     = shifted[XLEN-1:0] - opa[XLEN-1:0];
        if (div_mode) begin
            if (shifted >= divisor) begin
                acc_next = {{XLEN{1'b0}}, diff};
                opb_next = {opb[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {{XLEN{1'b0}}, shifted[XLEN-1:0]};
                opb_next = {opb[XLEN-2:0], 1'b0};
            end
        end else begin
            if (opb[0]) begin
                acc_next = acc + opa;
            end
            opa_next = {opa[2*XLEN-2:0], 1'b0};
            opb_next = {1'b0, opb[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: radix-2 shift-add multiply and restoring
// divide behind a valid/ready request/response handshake.
// Timeline after accept: PREP (1), CALC (XLEN), FIX (1), DONE.
// Special cases (divide by zero, signed overflow, non-M op) skip to DONE.
// Optional feature macro: MULDIV_EARLY_OUT_EN -- when defined, MUL-family
// ops leave CALC as soon as the shifted multiplier becomes zero.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = MXLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [4:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_ITER    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] DIV_ZERO_RES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] DIV_OVF_RES  = {1'b1, {(XLEN-1){1'b0}}};

    state_t             state_reg;
    step_mode_t         mode_reg;
    logic [4:0]         op_reg;
    logic [XLEN-1:0]    a_reg;
    logic [XLEN-1:0]    b_reg;
    logic [2*XLEN-1:0]  acc_reg;
    logic [2*XLEN-1:0]  opa_reg;
    logic [XLEN-1:0]    opb_reg;
    logic [CW-1:0]      cnt_reg;
    logic               neg_res_reg;
    logic               neg_rem_reg;
    logic               resp_valid_reg;
    logic [XLEN-1:0]    resp_data_reg;

    logic [2*XLEN-1:0]  acc_next;
    logic [2*XLEN-1:0]  opa_next;
    logic [XLEN-1:0]    opb_next;
    logic               early_exit;

    logic               sign_a;
    logic               sign_b;
    logic [XLEN-1:0]    mag_a;
    logic [XLEN-1:0]    mag_b;
    logic               special_hit;
    logic [XLEN-1:0]    special_data;

    logic [2*XLEN-1:0]  prod_fixed;
    logic [XLEN-1:0]    quo_fixed;
    logic [XLEN-1:0]    rem_fixed;
    logic [XLEN-1:0]    fix_data;

    assign req_ready  = (state_reg == ST_IDLE) && !rst;
    assign busy       = (state_reg != ST_IDLE);
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;

    muldiv_seq_step #(
        .XLEN(XLEN)
    ) u_step (
        .div_mode (mode_reg == STEP_DIV),
        .acc      (acc_reg),
        .opa      (opa_reg),
        .opb      (opb_reg),
        .acc_next (acc_next),
        .opa_next (opa_next),
        .opb_next (opb_next)
    );

`ifdef MULDIV_EARLY_OUT_EN
    // Multiplier fully consumed: remaining iterations would add nothing
    assign early_exit = (mode_reg == STEP_MUL) && (opb_next == '0);
`else
    assign early_exit = 1'b0;
`endif

    // Operand magnitudes and sign flags from the latched request
    always_comb begin
        sign_a = a_is_signed(op_reg) && a_reg[XLEN-1];
        sign_b = b_is_signed(op_reg) && b_reg[XLEN-1];
        mag_a  = sign_a ? (~a_reg + 1'b1) : a_reg;
        mag_b  = sign_b ? (~b_reg + 1'b1) : b_reg;
    end

    // Results that need no iteration
    always_comb begin
        special_hit  = 1'b0;
        special_data = '0;
        if (!is_mul_op(op_reg) && !is_div_op(op_reg)) begin
            special_hit = 1'b1;
        end else if (is_div_op(op_reg) && (b_reg == '0)) begin
            special_hit  = 1'b1;
            special_data = ((op_reg == ALU_DIV) || (op_reg == ALU_DIVU)) ? DIV_ZERO_RES : a_reg;
        end else if ((a_reg == DIV_OVF_RES) && (b_reg == '1)) begin
            if (op_reg == ALU_DIV) begin
                special_hit  = 1'b1;
                special_data = DIV_OVF_RES;
            end else if (op_reg == ALU_REM) begin
                special_hit  = 1'b1;
                special_data = '0;
            end
        end
    end

    // Sign fixup and word selection of the finished magnitude result
    always_comb begin
        prod_fixed = neg_res_reg ? (~acc_reg + 1'b1) : acc_reg;
        quo_fixed  = neg_res_reg ? (~opb_reg + 1'b1) : opb_reg;
        rem_fixed  = neg_rem_reg ? (~acc_reg[XLEN-1:0] + 1'b1) : acc_reg[XLEN-1:0];
        case (op_reg)
            ALU_MUL:                         fix_data = prod_fixed[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU: fix_data = prod_fixed[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:               fix_data = quo_fixed;
            ALU_REM, ALU_REMU:               fix_data = rem_fixed;
            default:                         fix_data = '0;
        endcase
    end

    // Sequencer FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            mode_reg       <= STEP_MUL;
            op_reg         <= '0;
            a_reg          <= '0;
            b_reg          <= '0;
            acc_reg        <= '0;
            opa_reg        <= '0;
            opb_reg        <= '0;
            cnt_reg        <= '0;
            neg_res_reg    <= 1'b0;
            neg_rem_reg    <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_data_reg  <= '0;
        end else if (flush) begin
            state_reg      <= ST_IDLE;
            resp_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_reg    <= req_op;
                        a_reg     <= req_a;
                        b_reg     <= req_b;
                        state_reg <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    neg_res_reg <= sign_a ^ sign_b;
                    neg_rem_reg <= sign_a;
                    cnt_reg     <= '0;
                    acc_reg     <= '0;
                    if (is_div_op(op_reg)) begin
                        mode_reg <= STEP_DIV;
                        opa_reg  <= {{XLEN{1'b0}}, mag_b};
                        opb_reg  <= mag_a;
                    end else begin
                        mode_reg <= STEP_MUL;
                        opa_reg  <= {{XLEN{1'b0}}, mag_a};
                        opb_reg  <= mag_b;
                    end
                    if (special_hit) begin
                        resp_data_reg  <= special_data;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= ST_DONE;
                    end else begin
                        state_reg <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc_reg <= acc_next;
                    opa_reg <= opa_next;
                    opb_reg <= opb_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if ((cnt_reg == LAST_ITER) || early_exit) begin
                        state_reg <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    resp_data_reg  <= fix_data;
                    resp_valid_reg <= 1'b1;
                    state_reg      <= ST_DONE;
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        resp_valid_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M corner cases, handshake,
// flush and reset behaviour, then randomized ops against a plain-arithmetic
// reference model (results and response latency).
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_seq #(
        .XLEN(32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural RV32M result, computed with 64-bit / native arithmetic
    function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] xa_s, xb_s, xa_u, xb_u, p;
        logic        ovf;
        xa_s = {{32{a[31]}}, a};
        xb_s = {{32{b[31]}}, b};
        xa_u = {32'b0, a};
        xb_u = {32'b0, b};
        ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            ALU_MUL:    begin p = xa_u * xb_u; return p[31:0];  end
            ALU_MULH:   begin p = xa_s * xb_s; return p[63:32]; end
            ALU_MULHSU: begin p = xa_s * xb_u; return p[63:32]; end
            ALU_MULHU:  begin p = xa_u * xb_u; return p[63:32]; end
            ALU_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            ALU_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            ALU_REMU:   return (b == 0) ? a : a % b;
            default:    return 32'h0;
        endcase
    endfunction

    // Cycle (counted from the accept cycle) in which resp_valid rises
    function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        logic        is_mul, is_div, ovf;
        logic [31:0] mb;
        int          n;
        is_mul = (op >= ALU_MUL) && (op <= ALU_MULHU);
        is_div = (op >= ALU_DIV) && (op <= ALU_REMU);
        ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF) && (op == ALU_DIV || op == ALU_REM);
        if (!is_mul && !is_div) return 2;
        if (is_div && (b == 0 || ovf)) return 2;
        mb = (op == ALU_MULH && b[31]) ? -b : b;
        n  = 1;
        for (int i = 0; i < 32; i++) begin
            if (mb[i]) n = i + 1;
        end
`ifdef MULDIV_EARLY_OUT_EN
        if (is_mul) return 3 + n;
`endif
        return 35;
    endfunction

    // One complete transaction: accept, wait, optional backpressure, consume
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int stall);
        logic [31:0] exp_data;
        logic [31:0] held;
        int          exp_lat;
        int          cyc;
        exp_data  = ref_result(op, a, b);
        exp_lat   = ref_latency(op, a, b);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        check("req_ready_idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        cyc       = 1;
        check("busy_after_accept", busy, 1);
        while (resp_valid !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("latency", cyc, exp_lat);
        check("resp_data", resp_data, exp_data);
        held = resp_data;
        repeat (stall) begin
            tick();
            check("hold_valid", resp_valid, 1);
            check("hold_data", resp_data, held);
            check("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("single_response", resp_valid, 0);
        check("ready_after_done", req_ready, 1);
        $display("op=%h a=%h b=%h result=%h expected=%h latency=%0d", op, a, b, held, exp_data, cyc);
    endtask

    initial begin
        int          seen;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        rst        = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 5'h0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Multiply results
        run_op(ALU_MUL, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(ALU_MULH, 32'hFFFF_FFF0, 32'd3, 0);

        // Division by zero and signed overflow
        run_op(ALU_DIV, 32'd100, 32'd0, 0);
        run_op(ALU_REMU, 32'd100, 32'd0, 0);
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(ALU_DIV, -32'sd7, 32'd2, 0);
        run_op(ALU_REM, -32'sd7, 32'd2, 0);
        run_op(5'h03, 32'd9, 32'd9, 0);

        // Backpressure: result held for 5 cycles
        run_op(ALU_DIVU, 32'd1000, 32'd7, 5);

        // Flush in cycle 10: no response, ready again in cycle 11
        req_op    = ALU_MUL;
        req_a     = 32'd7;
        req_b     = 32'd9;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_req_ready", req_ready, 1);
        check("flush_resp_valid", resp_valid, 0);
        seen = 0;
        repeat (40) begin
            tick();
            if (resp_valid === 1'b1) seen++;
        end
        check("flush_no_response", seen, 0);
        run_op(ALU_MULHSU, -32'sd2, 32'd3, 0);

        // Flush wins over a simultaneous request
        req_op    = ALU_MUL;
        req_a     = 32'd2;
        req_b     = 32'd2;
        req_valid = 1'b1;
        flush     = 1'b1;
        tick();
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_beats_accept", busy, 0);

        // Early-out latency (35 when the feature is absent)
        run_op(ALU_MUL, 32'd5, 32'd3, 0);

        // Reset in the middle of an operation clears outputs
        req_op    = ALU_DIVU;
        req_a     = 32'd12345;
        req_b     = 32'd11;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        #1;
        check("midrst_req_ready", req_ready, 0);
        tick();
        check("midrst_busy", busy, 0);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_resp_data", resp_data, 0);
        rst = 1'b0;
        tick();

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            int r;
            int cls;
            r   = $urandom_range(0, 8);
            op  = (r == 8) ? 5'h0B : (ALU_MUL + 5'(r));
            cls = $urandom_range(0, 4);
            a   = $urandom;
            b   = $urandom;
            case (cls)
                1: b = $urandom_range(0, 255);
                2: b = 32'h0;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin a = $urandom_range(0, 1000); b = -($urandom_range(1, 50)); end
                default: ;
            endcase
            run_op(op, a, b, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
